nzcv_flag_register: RTL
=======================

Name: nzcv_flag_register

Overview:
- Producer side of the condition-flag interface: computes N, Z, C, V for flag-setting instructions (ADDS/ADDIS/SUBS/SUBIS/CMP/ANDS) and holds them in an architectural NZCV register.
- Registered outputs drive the negative/zero/carry/overflow inputs of the branch-source logic, so B.cond sees the flags set by the most recent completed flag-setting instruction.
- Also provides a direct write port for restoring saved flags (context restore / MSR NZCV).

Parameters:
- WIDTH, 64, datapath width of operands. Flag bit positions derive from WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- set_flags  input  1  current instruction is flag-setting; capture computed flags this edge.
- flag_op  input  2  00 = ADD, 01 = SUB, 10 = LOGIC (AND), 11 = reserved.
- operand_a  input  WIDTH  first ALU operand (Rn).
- operand_b  input  WIDTH  second ALU operand (Rm or extended immediate).
- flags_we  input  1  direct write of flags_in.
- flags_in  input  4  {N,Z,C,V} value for direct write.
- negative  output  1  registered N.
- zero  output  1  registered Z.
- carry  output  1  registered C.
- overflow  output  1  registered V.
- flags_updated  output  1  one-cycle pulse: NZCV changed source this cycle (any write accepted on the previous edge).
- update_count  output  8  saturating count of accepted flag writes since reset (debug/perf).

Behaviour:
- Single clock, synchronous active-high reset. On reset edge: negative=0, zero=0, carry=0, overflow=0, flags_updated=0, update_count=0. Reset overrides every other input on the same edge.
- Combinational flag calculation (internal, WIDTH+1-bit arithmetic):
  - ADD: sum = {0,a} + {0,b}; res = sum[WIDTH-1:0]; C = sum[WIDTH]; V = (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
  - SUB: sum = {0,a} + {0,~b} + 1; C = sum[WIDTH] (1 = no borrow, i.e. a >= b unsigned); V = (a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
  - LOGIC: res = a & b; C = 0; V = 0.
  - All ops: N = res[MSB]; Z = (res == 0).
  - Reserved op 11: computed flags equal current register contents, i.e. no change. The write is still counted and still pulses flags_updated.
- Update priority per rising edge: reset > flags_we > set_flags > hold.
  - flags_we=1: {N,Z,C,V} <= flags_in; set_flags is ignored that edge.
  - set_flags=1 (flags_we=0): register <= computed flags.
  - Neither asserted: hold all four bits.
- Latency: flags visible on outputs exactly one cycle after the edge that captured them; no combinational path from inputs to flag outputs.
- flags_updated: registered. It is 1 in the cycle after any edge where flags_we or set_flags was accepted, and 0 otherwise, including when the written value equals the old value. Back-to-back writes hold it high continuously.
- update_count: increments by 1 per accepted write. It saturates at 255 and does not wrap.
- Operands are don't-care when set_flags=0 and must not affect state.
- Reset asserted in the same cycle as set_flags or flags_we: reset wins, and the write is lost and not counted.

Test Plan:
- Reset with set_flags=1, flag_op=ADD, a=1, b=1 -> next cycle NZCV=0000, flags_updated=0, update_count=0.
- SUB, a=5, b=5, set_flags=1 -> next cycle N=0 Z=1 C=1 V=0; then SUB a=3, b=5 -> N=1 Z=0 C=0 V=0.
- ADD, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> N=1 Z=0 C=0 V=1; ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> N=0 Z=1 C=1 V=0.
- Set flags to C=1,V=1 via SUB a=0x8000_0000_0000_0000, b=1, then LOGIC a=0xF0, b=0x0F -> NZCV=0100. Holding with set_flags=0 and random operands for 5 cycles leaves NZCV=0100 and flags_updated=0.
- flags_we=1, flags_in=1010 and set_flags=1 (SUB 5,5) on the same edge -> NZCV=1010, update_count +1 (not +2), flags_updated=1 for one cycle.
- Assert set_flags for 300 consecutive cycles -> update_count stops at 255, and flags_updated stays 1 throughout and drops the cycle after set_flags deasserts.

Source files
------------

// File: rtl/nzcv_flag_register.sv
// nzcv_flag_register
//   Computes N/Z/C/V for flag-setting ALU instructions (ADD, SUB, AND) and
//   holds them in the architectural NZCV register that feeds B.cond.
//   A direct write port restores saved flags (context restore / MSR NZCV).
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   set_flags     capture computed flags on this edge
//   flag_op       00 ADD, 01 SUB, 10 LOGIC (AND), 11 reserved (no change)
//   operand_a     first ALU operand (Rn)
//   operand_b     second ALU operand (Rm or extended immediate)
//   flags_we      direct write of flags_in, takes priority over set_flags
//   flags_in      {N,Z,C,V} for the direct write
//   negative      registered N
//   zero          registered Z
//   carry         registered C
//   overflow      registered V
//   flags_updated one-cycle pulse after any accepted write
//   update_count  saturating count of accepted writes since reset
module nzcv_flag_register #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_flags,
  input  logic [1:0]       flag_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             flags_updated,
  output logic [7:0]       update_count
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOGIC = 2'b10,
    OP_RSVD  = 2'b11
  } flag_op_t;

  localparam int unsigned MSB = WIDTH - 1;

  flag_op_t         op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             n_next;
  logic             z_next;
  logic             c_next;
  logic             v_next;
  logic             write_accepted;

  assign op             = flag_op_t'(flag_op);
  assign write_accepted = flags_we | set_flags;

  always_comb begin
    sum    = '0;
    res    = '0;
    n_next = negative;
    z_next = zero;
    c_next = carry;
    v_next = overflow;
    unique case (op)
      OP_ADD: begin
        sum    = {1'b0, operand_a} + {1'b0, operand_b};
        res    = sum[WIDTH-1:0];
        n_next = res[MSB];
        z_next = (res == '0);
        c_next = sum[WIDTH];
        v_next = (operand_a[MSB] == operand_b[MSB]) && (res[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        // Two's-complement subtract: carry out set means no borrow (a >= b).
        sum    = {1'b0, operand_a} + {1'b0, ~operand_b} + (WIDTH+1)'(1);
        res    = sum[WIDTH-1:0];
        n_next = res[MSB];
        z_next = (res == '0);
        c_next = sum[WIDTH];
        v_next = (operand_a[MSB] != operand_b[MSB]) && (res[MSB] != operand_a[MSB]);
      end
      OP_LOGIC: begin
        res    = operand_a & operand_b;
        n_next = res[MSB];
        z_next = (res == '0);
        c_next = 1'b0;
        v_next = 1'b0;
      end
      default: begin
        // Reserved op: recirculate current flags; the write still counts.
        n_next = negative;
        z_next = zero;
        c_next = carry;
        v_next = overflow;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      negative      <= 1'b0;
      zero          <= 1'b0;
      carry         <= 1'b0;
      overflow      <= 1'b0;
      flags_updated <= 1'b0;
      update_count  <= '0;
    end else begin
      flags_updated <= write_accepted;
      if (flags_we) begin
        {negative, zero, carry, overflow} <= flags_in;
      end else if (set_flags) begin
        {negative, zero, carry, overflow} <= {n_next, z_next, c_next, v_next};
      end
      if (write_accepted && (update_count != '1)) begin
        update_count <= update_count + 8'd1;
      end
    end
  end

endmodule
